alu_wb_stage: RTL

//  Execute-to-writeback stage directly downstream of the ALU. Captures ALU result, destination and NZCV.

---
 rtl/alu_wb_stage_pkg.sv | 31 +++
 rtl/alu_wb_stage_wb_fifo2.sv | 56 +++++
 rtl/alu_wb_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage: opcode encoding and the
// compare-class decode that suppresses register writes.
package alu_wb_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_EOR = 4'h1,
        ALU_SUB = 4'h2,
        ALU_RSB = 4'h3,
        ALU_ADD = 4'h4,
        ALU_ADC = 4'h5,
        ALU_SBC = 4'h6,
        ALU_RSC = 4'h7,
        ALU_TST = 4'h8,
        ALU_TEQ = 4'h9,
        ALU_CMP = 4'hA,
        ALU_CMN = 4'hB,
        ALU_ORR = 4'hC,
        ALU_MOV = 4'hD,
        ALU_BIC = 4'hE,
        ALU_MVN = 4'hF
    } alu_op_e;

    localparam int PC_REG = 15;

    // Compare-class ops only produce flags; they never write a register.
    function automatic logic is_alu_cmp(input logic [3:0] op);
        return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
    endfunction

endpackage

// File: rtl/alu_wb_stage_wb_fifo2.sv
// Two-entry skid FIFO between the ALU and the register-file write port.
// Flush empties it on the next edge and drops any coincident push.
module alu_wb_stage_wb_fifo2 #(
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             not_full
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign not_empty = (count_reg != 2'd0);
    assign not_full  = (count_reg != 2'd2);
    assign push_ok   = push & not_full & ~flush;
    assign pop_ok    = pop & not_empty;
    assign rd_data   = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (flush) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: architectural NZCV, 2-deep result FIFO, PC-write flag.
// Optional stall counter on o_stall_cnt when ALU_WB_PERF_EN is defined.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_opcode,
    input  logic              i_set_flags,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [DATA_W-1:0] i_result,
    input  logic [3:0]        i_nzcv,
    output logic [3:0]        o_flags,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic              o_wb_en,
    output logic [REG_W-1:0]  o_wb_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_pc_write
`ifdef ALU_WB_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt
`endif
);

    localparam int ENTRY_W = 1 + REG_W + DATA_W;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_we;
    logic [REG_W-1:0]   head_rd;
    logic [DATA_W-1:0]  head_data;
    logic               push;
    logic               pop;
    logic [3:0]         flags_reg;

    assign push     = i_valid & o_ready;
    assign pop      = o_wb_valid & i_wb_ready;
    assign wr_entry = {~is_alu_cmp(i_opcode), i_rd, i_result};

    alu_wb_stage_wb_fifo2 #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_flush),
        .push      (push),
        .pop       (pop),
        .wr_data   (wr_entry),
        .rd_data   (head_entry),
        .not_empty (o_wb_valid),
        .not_full  (o_ready)
    );

    assign {head_we, head_rd, head_data} = head_entry;

    // Head fields are masked so an empty stage drives all-zero outputs.
    assign o_wb_en    = o_wb_valid & head_we;
    assign o_wb_rd    = o_wb_valid ? head_rd : '0;
    assign o_wb_data  = o_wb_valid ? head_data : '0;
    assign o_pc_write = o_wb_en & (head_rd == REG_W'(PC_REG));
    assign o_flags    = flags_reg;

    // Flags commit at push time so the very next ALU op sees them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags_reg <= 4'b0000;
        end else if (push && !i_flush && (i_set_flags || is_alu_cmp(i_opcode))) begin
            flags_reg <= i_nzcv;
        end
    end

`ifdef ALU_WB_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_reg <= 32'd0;
        end else if (o_wb_valid && !i_wb_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule
